// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch front-end for the multi-cycle RV32I core. Issues
//   word-aligned fetch requests, buffers returned words with their PCs in a
//   circular prefetch FIFO and hands them to the core over valid/ready.
//   A redirect flushes the FIFO, marks every in-flight fetch for discard and
//   restarts fetching at the new PC.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   mem_req_valid     fetch request valid
//   mem_req_ready     memory accepts the request this cycle
//   mem_req_addr      word-aligned fetch address
//   mem_resp_valid    response word valid (in order, one per accepted request)
//   mem_resp_data     returned instruction word
//   redirect          flush and restart fetch at redirect_pc
//   redirect_pc       new fetch PC (bits [1:0] ignored)
//   inst_valid        head instruction valid
//   inst_ready        core consumes the head this cycle
//   inst_data         head instruction word
//   inst_pc           PC of the head instruction
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;

    // Address of every accepted request, popped by every response
    // (kept or dropped), so response PCs stay aligned across redirects.
    logic [31:0]   pcq [DEPTH];
    logic [PW-1:0] pcq_rd, pcq_wr;

    logic          accept;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_sum;
    logic [CW-1:0] outstanding_nxt;

    always_comb begin
        credit_sum      = {1'b0, count} + {1'b0, outstanding};
        // Buffered plus in-flight words never exceed DEPTH, so every
        // response is guaranteed a FIFO slot.
        mem_req_valid   = !rst && !redirect && (credit_sum < DEPTH_W);
        mem_req_addr    = {fetch_pc[31:2], 2'b00};
        accept          = mem_req_valid && mem_req_ready;
        inst_valid      = !rst && (count != '0);
        inst_data       = fifo_data[rd_ptr];
        inst_pc         = fifo_pc[rd_ptr];
        pop             = inst_valid && inst_ready;
        push            = mem_resp_valid && !redirect && (drop == '0);
        outstanding_nxt = outstanding + CW'(accept) - CW'(mem_resp_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (mem_resp_valid) begin
                pcq_rd <= pcq_rd + PW'(1);
            end
            if (accept) begin
                pcq_wr <= pcq_wr + PW'(1);
            end
            if (redirect) begin
                // Every request still in flight after this cycle is stale;
                // outstanding already includes any earlier pending drops.
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                drop     <= outstanding_nxt;
                rd_ptr   <= wr_ptr;
                count    <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= mem_req_addr + 32'd4;
                end
                if (mem_resp_valid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset; occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            pcq[pcq_wr] <= mem_req_addr;
        end
        if (!rst && push) begin
            fifo_pc[wr_ptr]   <= pcq[pcq_rd];
            fifo_data[wr_ptr] <= mem_resp_data;
        end
    end

endmodule
